// File: rtl/temp_sample_scheduler.sv
// temp_sample_scheduler
//   Periodically starts a TMP101 read, waits for the reader's Done rising
//   edge, captures the temperature byte and maintains latest / 4-sample
//   average / min / max / count. Optional over-temperature alarm with
//   hysteresis is compiled in with `define TEMP_ALARM_EN.
//
// Ports
//   Clock, Reset       system clock, async active-high reset
//   Enable             level, periodic sampling every SampleInterval cycles
//   ReadNow            one-cycle request for an immediate read
//   Done, ReceivedData reader handshake (Done is a level, only rising edges count)
//   StartRead          one-cycle start pulse to the reader
//   Busy               read in flight (StartRead .. capture/timeout)
//   SampleValid        one-cycle pulse when the statistics below update
//   Temperature, Average, MaxTemp, MinTemp  signed 8-bit statistics
//   SampleCount        captured samples, saturating at 255
//   TimeoutFlag        sticky read-timeout flag, cleared by next capture
//   Alarm              over-temperature flag (0 when TEMP_ALARM_EN undefined)
module temp_sample_scheduler #(
    parameter int unsigned SampleInterval = 75000000,
    parameter int unsigned DoneTimeout    = 7500000
`ifdef TEMP_ALARM_EN
    ,
    parameter logic signed [7:0] AlarmHigh = 8'sd40,
    parameter logic [7:0]        AlarmHyst = 8'd2
`endif
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       ReadNow,
    input  logic       Done,
    input  logic [7:0] ReceivedData,
    output logic       StartRead,
    output logic       Busy,
    output logic       SampleValid,
    output logic [7:0] Temperature,
    output logic [7:0] Average,
    output logic [7:0] MaxTemp,
    output logic [7:0] MinTemp,
    output logic [7:0] SampleCount,
    output logic       TimeoutFlag,
    output logic       Alarm
);

    localparam int IW = (SampleInterval > 1) ? $clog2(SampleInterval) : 1;
    localparam int TW = (DoneTimeout > 1) ? $clog2(DoneTimeout) + 1 : 2;
    localparam logic [IW-1:0] ILAST = IW'(SampleInterval - 1);
    localparam logic [TW-1:0] TLAST = TW'(DoneTimeout - 1);

    typedef enum logic [2:0] {IDLE, WAIT_TICK, START, WAIT_DONE, CAPTURE} state_t;

    state_t          state, next;
    logic [IW-1:0]   tick_cnt;
    logic [TW-1:0]   to_cnt;
    logic            doneq;
    logic [7:0]      sample;
    logic [3:0][7:0] hist;
    logic            have_hist;
    logic [3:0][7:0] new_hist;
    logic signed [9:0] sum;
    logic signed [9:0] avg_shr;
    logic            done_rise;
    logic            timeout;

    // doneq simply trails Done by one cycle; in the first WAIT_DONE cycle it
    // therefore holds the level seen during START, so a Done already high
    // when the read starts never counts as an edge.
    assign done_rise = (state == WAIT_DONE) && !doneq && Done;
    assign timeout   = (state == WAIT_DONE) && !done_rise && (to_cnt == TLAST);

    always_comb begin
        next = state;
        case (state)
            IDLE:      if (ReadNow) next = START;
                       else if (Enable) next = WAIT_TICK;
            WAIT_TICK: if (ReadNow) next = START;
                       else if (!Enable) next = IDLE;
                       else if (tick_cnt == ILAST) next = START;
            START:     next = WAIT_DONE;
            WAIT_DONE: if (done_rise) next = CAPTURE;
                       else if (timeout) next = Enable ? WAIT_TICK : IDLE;
            CAPTURE:   next = Enable ? WAIT_TICK : IDLE;
            default:   next = IDLE;
        endcase
    end

    // First sample primes the whole history so the average is meaningful
    // immediately.
    always_comb begin
        new_hist = have_hist ? {hist[2:0], sample} : {4{sample}};
        sum = '0;
        for (int i = 0; i < 4; i++)
            sum = sum + {{2{new_hist[i][7]}}, new_hist[i]};
        avg_shr = sum >>> 2;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            to_cnt      <= '0;
            doneq       <= 1'b0;
            sample      <= '0;
            hist        <= '0;
            have_hist   <= 1'b0;
            StartRead   <= 1'b0;
            Busy        <= 1'b0;
            SampleValid <= 1'b0;
            Temperature <= '0;
            Average     <= '0;
            MaxTemp     <= '0;
            MinTemp     <= '0;
            SampleCount <= '0;
            TimeoutFlag <= 1'b0;
        end else begin
            state       <= next;
            tick_cnt    <= (state == WAIT_TICK && next == WAIT_TICK) ? tick_cnt + 1'b1 : '0;
            to_cnt      <= (state == WAIT_DONE) ? to_cnt + 1'b1 : '0;
            doneq       <= Done;
            StartRead   <= (next == START);
            SampleValid <= (state == CAPTURE);

            if (next == START) Busy <= 1'b1;
            else if (state == CAPTURE || timeout) Busy <= 1'b0;

            if (done_rise) sample <= ReceivedData;
            if (timeout) TimeoutFlag <= 1'b1;

            if (state == CAPTURE) begin
                Temperature <= sample;
                TimeoutFlag <= 1'b0;
                hist        <= new_hist;
                have_hist   <= 1'b1;
                Average     <= avg_shr[7:0];
                if (SampleCount != 8'hFF) SampleCount <= SampleCount + 8'd1;
                if (!have_hist || $signed(sample) > $signed(MaxTemp)) MaxTemp <= sample;
                if (!have_hist || $signed(sample) < $signed(MinTemp)) MinTemp <= sample;
            end
        end
    end

`ifdef TEMP_ALARM_EN
    localparam logic signed [8:0] ALARM_SET = 9'(AlarmHigh);
    localparam logic signed [8:0] ALARM_CLR = 9'(AlarmHigh) - $signed({1'b0, AlarmHyst});
    logic signed [8:0] sample_x;
    assign sample_x = {sample[7], sample};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) Alarm <= 1'b0;
        else if (state == CAPTURE) begin
            if (sample_x >= ALARM_SET) Alarm <= 1'b1;
            else if (sample_x <= ALARM_CLR) Alarm <= 1'b0;
        end
    end
`else
    assign Alarm = 1'b0;
`endif

endmodule
